// File: rtl/logic_op_scheduler.sv
// Round-robin scheduler sharing one DATA_W-bit AND/OR/XOR/NOT unit among N_REQ requesters.
// One operation at a time: accept in IDLE, compute in EXEC, hold the response in RESP.
module logic_op_scheduler #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ID_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [2*N_REQ-1:0]        req_op,
    input  logic [DATA_W*N_REQ-1:0]   req_a,
    input  logic [DATA_W*N_REQ-1:0]   req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned OP_W  = 2;

    localparam logic [OP_W-1:0] OP_AND = 2'b00;
    localparam logic [OP_W-1:0] OP_OR  = 2'b01;
    localparam logic [OP_W-1:0] OP_XOR = 2'b10;
    localparam logic [OP_W-1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [OP_W-1:0]   op_arr [N_REQ];
    logic [DATA_W-1:0] a_arr  [N_REQ];
    logic [DATA_W-1:0] b_arr  [N_REQ];

    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  scan_idx;
    logic              grant_found;
    logic              accept;

    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [IDX_W-1:0]  id_q;
    logic [DATA_W-1:0] result_c;

    // Unpack the flat per-requester request buses into indexable arrays.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign op_arr[gi] = req_op[OP_W*gi +: OP_W];
        assign a_arr[gi]  = req_a[DATA_W*gi +: DATA_W];
        assign b_arr[gi]  = req_b[DATA_W*gi +: DATA_W];
    end

    // Round-robin search starting just after the last served requester.
    always_comb begin
        req_ready   = '0;
        grant_idx   = last_grant;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            scan_idx = IDX_W'((int'(last_grant) + k) % int'(N_REQ));
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        // Grant is only offered while idle and out of reset.
        if ((state_q == IDLE) && !rst && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = |req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept)    state_d = EXEC;
            EXEC:                state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // The shared logic unit; results are exactly DATA_W bits.
    always_comb begin
        result_c = '0;
        unique case (op_q)
            OP_AND:  result_c = a_q & b_q;
            OP_OR:   result_c = a_q | b_q;
            OP_XOR:  result_c = a_q ^ b_q;
            OP_NOT:  result_c = ~a_q;
            default: result_c = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
            last_grant <= IDX_W'(N_REQ - 1);
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q <= op_arr[grant_idx];
                        a_q  <= a_arr[grant_idx];
                        b_q  <= b_arr[grant_idx];
                        id_q <= grant_idx;
                    end
                end
                EXEC: begin
                    rsp_result <= result_c;
                    rsp_id     <= ID_W'(id_q);
                end
                RESP: begin
                    // Priority advances only once the response is consumed.
                    if (rsp_ready) begin
                        last_grant <= id_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Directed bench for logic_op_scheduler: reset, single ops, opcode sweep,
// round-robin order and spacing, backpressure, and reset mid-operation.
module tb_logic_op_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 4;
    localparam int unsigned IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_op;
    logic [W*N-1:0]  req_a;
    logic [W*N-1:0]  req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [W-1:0]    rsp_result;
    logic            busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [W-1:0] rr_exp [N];

    logic_op_scheduler #(.N_REQ(N), .DATA_W(W), .ID_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]       = v;
        req_op[2*i +: 2]   = op;
        req_a[W*i +: W]    = a;
        req_b[W*i +: W]    = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated operation with rsp_ready held high.
    task automatic single_op(input int i, input logic [1:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] exp);
        @(negedge clk);
        set_req(i, 1'b1, op, a, b);
        #1;
        check("single_grant", 32'(req_ready), 32'(1 << i));
        @(posedge clk);
        #1 req_valid[i] = 1'b0;
        @(negedge clk);
        check("exec_valid", 32'(rsp_valid), 0);
        check("exec_busy", 32'(busy), 1);
        @(negedge clk);
        check("resp_valid", 32'(rsp_valid), 1);
        check("resp_id", 32'(rsp_id), 32'(i));
        check("resp_result", 32'(rsp_result), 32'(exp));
        @(negedge clk);
        check("done_valid", 32'(rsp_valid), 0);
        check("done_busy", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_cyc;
        int t;
        logic seen;

        rr_exp[0] = 4'b0101;
        rr_exp[1] = 4'b0011;
        rr_exp[2] = 4'b0110;
        rr_exp[3] = 4'b1100;

        // Reset with random inputs applied.
        rst       = 1'b1;
        req_valid = N'($urandom);
        req_op    = (2*N)'($urandom);
        req_a     = (W*N)'($urandom);
        req_b     = (W*N)'($urandom);
        rsp_ready = 1'($urandom);
        repeat (3) begin
            @(negedge clk);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_req_ready", 32'(req_ready), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_result", 32'(rsp_result), 0);
        end
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        rst       = 1'b0;

        // Single NOT operations on requester 0.
        single_op(0, 2'b11, 4'b1001, 4'b0000, 4'b0110);
        single_op(0, 2'b11, 4'b0110, 4'b1111, 4'b1001);

        // Opcode sweep on requester 2.
        single_op(2, 2'b00, 4'b1100, 4'b1010, 4'b1000);
        single_op(2, 2'b01, 4'b1100, 4'b1010, 4'b1110);
        single_op(2, 2'b10, 4'b1100, 4'b1010, 4'b0110);

        // Round-robin with all requesters active.
        do_reset();
        @(negedge clk);
        set_req(0, 1'b1, 2'b00, 4'b1111, 4'b0101);
        set_req(1, 1'b1, 2'b01, 4'b0001, 4'b0010);
        set_req(2, 1'b1, 2'b10, 4'b1100, 4'b1010);
        set_req(3, 1'b1, 2'b11, 4'b0011, 4'b1111);
        #1;
        last_cyc = cyc;
        for (int n = 0; n < 5; n++) begin
            t = 0;
            while (req_ready == '0 && t < 10) begin
                @(negedge clk);
                #1;
                t++;
            end
            check("rr_grant", 32'(req_ready), 32'(1 << (n % 4)));
            if (n > 0) check("rr_gap", 32'(cyc - last_cyc), 3);
            last_cyc = cyc;
            @(posedge clk);
            #1;
            if (n == 4) req_valid = '0;
            @(negedge clk);
            @(negedge clk);
            check("rr_valid", 32'(rsp_valid), 1);
            check("rr_id", 32'(rsp_id), 32'(n % 4));
            check("rr_result", 32'(rsp_result), 32'(rr_exp[n % 4]));
            @(negedge clk);
            #1;
        end

        // Backpressure: response held, later requester waits and is not lost.
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 2'b10, 4'b1010, 4'b0110);
        #1;
        check("bp_grant", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        set_req(3, 1'b1, 2'b11, 4'b0101, 4'b0000);
        #1;
        for (int j = 0; j < 5; j++) begin
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_id", 32'(rsp_id), 1);
            check("bp_result", 32'(rsp_result), 32'b1100);
            check("bp_ready", 32'(req_ready), 0);
            @(negedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_valid", 32'(rsp_valid), 0);
        check("bp_pending_grant", 32'(req_ready), 32'b1000);
        @(posedge clk);
        #1 req_valid[3] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_next_valid", 32'(rsp_valid), 1);
        check("bp_next_id", 32'(rsp_id), 3);
        check("bp_next_result", 32'(rsp_result), 32'b1010);
        @(negedge clk);

        // Reset during EXEC discards the transaction.
        @(negedge clk);
        set_req(1, 1'b1, 2'b01, 4'b0011, 4'b0101);
        #1;
        check("mid_grant", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        check("mid_exec_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("mid_no_rsp", 32'(seen), 0);
        set_req(0, 1'b1, 2'b00, 4'b1110, 4'b0111);
        set_req(1, 1'b1, 2'b01, 4'b0011, 4'b0101);
        #1;
        check("post_rst_grant", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_id", 32'(rsp_id), 0);
        check("post_rst_result", 32'(rsp_result), 32'b0110);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
